// File: rtl/track_pkg.sv
// Shared constants and types for the label-tracking event generator and its helpers.
package track_pkg;

   localparam int                LFSR_W         = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS      = 16'hB400;
   localparam int                DEF_LABELWIDTH = 20;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

endpackage

// File: rtl/track_lfsr.sv
// 16-bit right-shifting Galois LFSR with a load-on-reset seed and an advance enable.
module track_lfsr
   import track_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         value <= SEED;
      end else if (advance) begin
         value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
      end
   end

endmodule

// File: rtl/track_gen.sv
// Issues N unique labels and retires each once in LFSR-scrambled order, with optional
// one-shot bogus retire; keeps a swap-remove table of outstanding labels.
module track_gen
   import track_pkg::*;
#(
   parameter int                    LABELWIDTH = DEF_LABELWIDTH,
   parameter int                    OUTLOG2    = 4,
   parameter logic [LABELWIDTH-1:0] LABEL_BASE = '0,
   parameter logic [LFSR_W-1:0]     SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset_l,
   input  logic                  start,
   input  logic [15:0]           issue_count,
   input  logic                  inject_error,
   input  logic                  track_fifo_full,
   output logic [LABELWIDTH-1:0] track_label,
   output logic                  track_mark,
   output logic                  track_fifo_we,
   output logic                  busy,
   output logic                  done,
   output logic [OUTLOG2:0]      outstanding
);

   localparam int             DEPTH    = 1 << OUTLOG2;
   localparam logic [OUTLOG2:0] FULL_CNT = (OUTLOG2 + 1)'(DEPTH);

   state_t                state, state_nx;
   logic [15:0]           n_q, issued_q;
   logic [LABELWIDTH-1:0] label_q;
   logic [LABELWIDTH-1:0] tbl [DEPTH];
   logic                  arm_q;
   logic [LFSR_W-1:0]     lfsr;
   logic                  do_issue, do_retire, bogus, fin_go;
   logic [OUTLOG2-1:0]    idx_raw, idx, last;
   logic [OUTLOG2:0]      last_full;
   logic                  unused_bits;

   track_lfsr #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .reset_l (reset_l),
      .advance (do_issue | do_retire),
      .value   (lfsr)
   );

   // Retire slot comes from LFSR bits above the issue/retire decision bit.
   always_comb begin
      idx_raw   = lfsr[OUTLOG2:1];
      idx       = ({1'b0, idx_raw} >= outstanding) ? '0 : idx_raw;
      last_full = outstanding - 1'b1;
      last      = last_full[OUTLOG2-1:0];
   end

   assign unused_bits = ^{lfsr[LFSR_W-1:OUTLOG2+1], last_full[OUTLOG2]};

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      do_issue  = 1'b0;
      do_retire = 1'b0;
      fin_go    = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            if (!track_fifo_full) begin
               if (issued_q == n_q && outstanding == '0) begin
                  state_nx = FIN;
                  fin_go   = 1'b1;
               end else if (outstanding == FULL_CNT || issued_q == n_q) begin
                  do_retire = 1'b1;
               end else if (outstanding == '0) begin
                  do_issue = 1'b1;
               end else if (lfsr[0]) begin
                  do_issue = 1'b1;
               end else begin
                  do_retire = 1'b1;
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bogus = do_retire & arm_q;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         n_q           <= '0;
         issued_q      <= '0;
         label_q       <= LABEL_BASE;
         arm_q         <= 1'b0;
         outstanding   <= '0;
         track_label   <= '0;
         track_mark    <= 1'b0;
         track_fifo_we <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else begin
         track_fifo_we <= do_issue | do_retire;
         track_mark    <= do_issue;
         track_label   <= '0;
         busy          <= (state_nx != IDLE);
         done          <= fin_go;
         if (state == IDLE && start) begin
            n_q      <= issue_count;
            issued_q <= '0;
         end
         if (bogus)             arm_q <= 1'b0;
         else if (inject_error) arm_q <= 1'b1;
         // A bogus retire emits the never-issued next label and leaves the table alone.
         if (do_issue) begin
            track_label                   <= label_q;
            tbl[outstanding[OUTLOG2-1:0]] <= label_q;
            label_q                       <= label_q + 1'b1;
            issued_q                      <= issued_q + 1'b1;
            outstanding                   <= outstanding + 1'b1;
         end else if (bogus) begin
            track_label <= label_q;
         end else if (do_retire) begin
            track_label <= tbl[idx];
            tbl[idx]    <= tbl[last];
            outstanding <= outstanding - 1'b1;
         end
      end
   end

endmodule
